// File: rtl/sifive_reset_sequencer_if.sv
// Warm-reset request and per-channel reset status bundle between a reset
// sequencer (slave) and the agent that requests warm resets (master).
interface sifive_reset_sequencer_if #(
  parameter int CHANNELS = 4
);
  logic                sw_req;
  logic [CHANNELS-1:0] sw_mask;
  logic [CHANNELS-1:0] reset;
  logic                done;
  logic                sw_ack;

  modport master (
    output sw_req,
    output sw_mask,
    input  reset,
    input  done,
    input  sw_ack
  );

  modport slave (
    input  sw_req,
    input  sw_mask,
    output reset,
    output done,
    output sw_ack
  );
endinterface

// File: rtl/sifive_reset_sequencer.sv
// Power-on and warm reset sequencer: synchronises board reset deassertion, holds all
// channels, then releases them one by one in ascending order with a fixed gap.
module sifive_reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 4,
  parameter int HOLD_CYCLES = 256,
  parameter int STAGE_GAP   = 16,
  parameter int SW_HOLD     = 32
) (
  input  logic                    clock,
  input  logic                    areset_n,
  sifive_reset_sequencer_if.slave seqIf
);

  localparam int MaxHoldGap = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CountMax   = (MaxHoldGap > SW_HOLD) ? MaxHoldGap : SW_HOLD;
  localparam int CW         = $clog2(CountMax + 1);
  localparam int IW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CW-1:0]       HoldLoad = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]       GapLoad  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0]       SwLoad   = CW'(SW_HOLD - 1);
  localparam logic [CW-1:0]       CountOne = CW'(1);
  localparam logic [IW-1:0]       LastIdx  = IW'(CHANNELS - 1);
  localparam logic [IW-1:0]       IdxOne   = IW'(1);
  localparam logic [CHANNELS-1:0] ChanOne  = CHANNELS'(1);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_SW_HOLD,
    ST_SW_RELEASE
  } state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  syncChain_q;
  logic [CW-1:0]           count_q;
  logic [IW-1:0]           chanIdx_q;
  logic [CHANNELS-1:0]     resetOut_q;
  logic                    done_q;
  logic                    swAck_q;

  logic                    syncHeld;
  logic [CHANNELS-1:0]     lowBit;
  logic [CHANNELS-1:0]     swRest_d;

  assign syncHeld = syncChain_q[SYNC_STAGES-1];

  // During a warm sequence the only channels still held are the masked ones that
  // have not been released yet, so the lowest held bit is always the next to go.
  assign lowBit   = resetOut_q & (~resetOut_q + ChanOne);
  assign swRest_d = resetOut_q & ~lowBit;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      syncChain_q <= '1;
      state_q     <= ST_HOLD;
      count_q     <= '0;
      chanIdx_q   <= '0;
      resetOut_q  <= '1;
      done_q      <= 1'b0;
      swAck_q     <= 1'b0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], 1'b0};
      swAck_q     <= 1'b0;
      case (state_q)
        ST_HOLD: begin
          if (syncHeld) begin
            count_q <= HoldLoad;
          end else if (count_q != '0) begin
            count_q <= count_q - CountOne;
          end else begin
            resetOut_q <= resetOut_q & ~ChanOne;
            if (CHANNELS == 1) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_RELEASE;
              chanIdx_q <= IdxOne;
              count_q   <= GapLoad;
            end
          end
        end

        ST_RELEASE: begin
          if (count_q != '0) begin
            count_q <= count_q - CountOne;
          end else begin
            resetOut_q <= resetOut_q & ~(ChanOne << chanIdx_q);
            if (chanIdx_q == LastIdx) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              chanIdx_q <= chanIdx_q + IdxOne;
              count_q   <= GapLoad;
            end
          end
        end

        ST_RUN: begin
          if (seqIf.sw_req && (seqIf.sw_mask != '0)) begin
            resetOut_q <= resetOut_q | seqIf.sw_mask;
            done_q     <= 1'b0;
            swAck_q    <= 1'b1;
            count_q    <= SwLoad;
            state_q    <= ST_SW_HOLD;
          end
        end

        ST_SW_HOLD, ST_SW_RELEASE: begin
          if (count_q != '0) begin
            count_q <= count_q - CountOne;
          end else begin
            resetOut_q <= swRest_d;
            if (swRest_d == '0) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SW_RELEASE;
              count_q <= GapLoad;
            end
          end
        end

        default: begin
          state_q <= ST_HOLD;
        end
      endcase
    end
  end

  assign seqIf.reset  = resetOut_q;
  assign seqIf.done   = done_q;
  assign seqIf.sw_ack = swAck_q;

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// Self-checking bench: a timeline model predicts each channel's rise/fall edge for a
// four-channel sequencer; a single-channel instance is checked with directed loops.
module tb_sifive_reset_sequencer;

  localparam int ASync   = 3;
  localparam int AHold   = 16;
  localparam int AGap    = 4;
  localparam int ASwHold = 8;
  localparam int BSwHold = 8;
  localparam int Inf     = 1 << 30;

  logic clock;
  logic aRst_n;
  logic bRst_n;

  sifive_reset_sequencer_if #(.CHANNELS(4)) aIf ();
  sifive_reset_sequencer_if #(.CHANNELS(1)) bIf ();

  sifive_reset_sequencer #(
    .CHANNELS(4), .SYNC_STAGES(ASync), .HOLD_CYCLES(AHold),
    .STAGE_GAP(AGap), .SW_HOLD(ASwHold)
  ) dutA (
    .clock(clock), .areset_n(aRst_n), .seqIf(aIf.slave)
  );

  sifive_reset_sequencer #(
    .CHANNELS(1), .SYNC_STAGES(2), .HOLD_CYCLES(1),
    .STAGE_GAP(1), .SW_HOLD(BSwHold)
  ) dutB (
    .clock(clock), .areset_n(bRst_n), .seqIf(bIf.slave)
  );

  int assertCount = 0;
  int failCount   = 0;
  int edgeNum     = 0;
  int ackEdge     = -1;
  int relAt [4];
  int riseAt[4];
  int modelOrder;
  logic checkEn = 1'b0;
  logic [3:0] expRst;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNum, actual, expected);
    end
  endtask

  function automatic bit allReleased(input int n);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++)
      if ((riseAt[k] <= n) && (n < relAt[k])) ok = 1'b0;
    return ok;
  endfunction

  // Channel k of the four-channel instance is high on edges in [riseAt, relAt).
  always @(posedge clock) begin
    edgeNum = edgeNum + 1;
    if ((aRst_n === 1'b1) && (aIf.sw_req === 1'b1) && (aIf.sw_mask != 4'b0) &&
        allReleased(edgeNum - 1)) begin
      modelOrder = 0;
      for (int k = 0; k < 4; k++) begin
        if (aIf.sw_mask[k]) begin
          riseAt[k]  = edgeNum;
          relAt[k]   = edgeNum + ASwHold + modelOrder * AGap;
          modelOrder = modelOrder + 1;
        end
      end
      ackEdge = edgeNum;
    end
  end

  always @(negedge aRst_n) begin
    for (int k = 0; k < 4; k++) begin
      riseAt[k] = 0;
      relAt[k]  = Inf;
    end
    ackEdge = -1;
  end

  always @(posedge aRst_n) begin
    for (int k = 0; k < 4; k++) relAt[k] = edgeNum + ASync + AHold + k * AGap;
  end

  always @(negedge clock) begin
    if (checkEn) begin
      for (int k = 0; k < 4; k++)
        expRst[k] = (riseAt[k] <= edgeNum) && (edgeNum < relAt[k]);
      checkOutput("model_reset", 32'(aIf.reset), 32'(expRst));
      checkOutput("model_done", 32'(aIf.done), 32'((expRst == 4'b0) && (aRst_n === 1'b1)));
      checkOutput("model_ack", 32'(aIf.sw_ack), 32'(ackEdge == edgeNum));
    end
  end

  task automatic waitEdge(input int n);
    while (edgeNum < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [3:0] mask);
    aIf.sw_req  = req;
    aIf.sw_mask = mask;
  endtask

  task automatic checkAt(input int n, input string name, input logic [3:0] rst,
                         input logic dn, input logic ack);
    waitEdge(n);
    checkOutput({name, "_reset"}, 32'(aIf.reset), 32'(rst));
    checkOutput({name, "_done"}, 32'(aIf.done), 32'(dn));
    checkOutput({name, "_ack"}, 32'(aIf.sw_ack), 32'(ack));
  endtask

  initial begin
    #200000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, r2, r3, r4, e, e2, rb, eb;
    for (int k = 0; k < 4; k++) begin
      riseAt[k] = 0;
      relAt[k]  = Inf;
    end
    aRst_n = 1'b0;
    bRst_n = 1'b0;
    applyStimulus(1'b0, 4'b0);
    bIf.sw_req  = 1'b0;
    bIf.sw_mask = 1'b0;
    #1 checkEn = 1'b1;

    $display("[TB] power-on sequence");
    waitEdge(5);
    aRst_n = 1'b1;
    r = edgeNum;
    checkAt(r + 18, "s1_e18", 4'b1111, 1'b0, 1'b0);
    checkAt(r + 19, "s1_e19", 4'b1110, 1'b0, 1'b0);
    checkAt(r + 23, "s1_e23", 4'b1100, 1'b0, 1'b0);
    waitEdge(r + 24);
    applyStimulus(1'b1, 4'b1111);
    waitEdge(r + 25);
    applyStimulus(1'b0, 4'b0);
    checkAt(r + 26, "s4_release_ignored", 4'b1100, 1'b0, 1'b0);
    checkAt(r + 27, "s1_e27", 4'b1000, 1'b0, 1'b0);
    checkAt(r + 30, "s1_e30", 4'b1000, 1'b0, 1'b0);
    checkAt(r + 31, "s1_e31", 4'b0000, 1'b1, 1'b0);

    $display("[TB] zero-mask request");
    waitEdge(r + 34);
    applyStimulus(1'b1, 4'b0);
    waitEdge(r + 35);
    applyStimulus(1'b0, 4'b0);
    checkAt(r + 36, "s4_zero_mask", 4'b0000, 1'b1, 1'b0);

    $display("[TB] areset pulse mid-release");
    waitEdge(r + 38);
    aRst_n = 1'b0;
    waitEdge(r + 40);
    aRst_n = 1'b1;
    r2 = edgeNum;
    checkAt(r2 + 25, "s2_e25", 4'b1100, 1'b0, 1'b0);
    aRst_n = 1'b0;
    #1;
    checkOutput("s2_async_reset", 32'(aIf.reset), 32'(4'b1111));
    checkOutput("s2_async_done", 32'(aIf.done), 32'(1'b0));
    waitEdge(r2 + 27);
    aRst_n = 1'b1;
    r3 = edgeNum;
    checkAt(r3 + 18, "s2_e18", 4'b1111, 1'b0, 1'b0);
    checkAt(r3 + 19, "s2_e19", 4'b1110, 1'b0, 1'b0);
    checkAt(r3 + 31, "s2_e31", 4'b0000, 1'b1, 1'b0);

    $display("[TB] warm reset of channels 1 and 3");
    waitEdge(r3 + 35);
    applyStimulus(1'b1, 4'b1010);
    e = r3 + 36;
    waitEdge(e);
    applyStimulus(1'b0, 4'b0101);
    checkAt(e, "s3_accept", 4'b1010, 1'b0, 1'b1);
    checkAt(e + 1, "s3_ack_drop", 4'b1010, 1'b0, 1'b0);
    waitEdge(e + 3);
    applyStimulus(1'b1, 4'b0101);
    waitEdge(e + 4);
    applyStimulus(1'b0, 4'b0);
    checkAt(e + 5, "s4_swhold_ignored", 4'b1010, 1'b0, 1'b0);
    checkAt(e + 7, "s3_e7", 4'b1010, 1'b0, 1'b0);
    checkAt(e + 8, "s3_e8", 4'b1000, 1'b0, 1'b0);
    checkAt(e + 11, "s3_e11", 4'b1000, 1'b0, 1'b0);
    checkAt(e + 12, "s3_e12", 4'b0000, 1'b1, 1'b0);

    $display("[TB] areset during warm release");
    waitEdge(e + 15);
    applyStimulus(1'b1, 4'b1010);
    e2 = e + 16;
    waitEdge(e2);
    applyStimulus(1'b0, 4'b0);
    checkAt(e2 + 8, "s6_e8", 4'b1000, 1'b0, 1'b0);
    waitEdge(e2 + 9);
    aRst_n = 1'b0;
    #1;
    checkOutput("s6_async_reset", 32'(aIf.reset), 32'(4'b1111));
    checkOutput("s6_async_done", 32'(aIf.done), 32'(1'b0));
    waitEdge(e2 + 12);
    aRst_n = 1'b1;
    r4 = edgeNum;
    checkAt(r4 + 19, "s6_e19", 4'b1110, 1'b0, 1'b0);
    checkAt(r4 + 23, "s6_e23", 4'b1100, 1'b0, 1'b0);
    checkAt(r4 + 27, "s6_e27", 4'b1000, 1'b0, 1'b0);
    checkAt(r4 + 31, "s6_e31", 4'b0000, 1'b1, 1'b0);

    $display("[TB] single-channel instance");
    waitEdge(r4 + 35);
    checkOutput("b_in_reset", 32'(bIf.reset), 32'(1'b1));
    bRst_n = 1'b1;
    rb = edgeNum;
    for (int n = rb + 1; n <= rb + 5; n++) begin
      waitEdge(n);
      checkOutput("b_por_reset", 32'(bIf.reset), 32'(n < rb + 3));
      checkOutput("b_por_done", 32'(bIf.done), 32'(n >= rb + 3));
    end
    bIf.sw_req  = 1'b1;
    bIf.sw_mask = 1'b1;
    eb = edgeNum + 1;
    waitEdge(eb);
    bIf.sw_req  = 1'b0;
    bIf.sw_mask = 1'b0;
    for (int n = eb; n <= eb + 10; n++) begin
      waitEdge(n);
      checkOutput("b_sw_reset", 32'(bIf.reset), 32'(n < eb + BSwHold));
      checkOutput("b_sw_done", 32'(bIf.done), 32'(n >= eb + BSwHold));
      checkOutput("b_sw_ack", 32'(bIf.sw_ack), 32'(n == eb));
    end

    waitEdge(edgeNum + 3);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
